// File: rtl/ps2_pkg.sv
// Shared byte constants, decoder state and event layout for the PS/2 scan-code controller.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } scan_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } scan_event_t;

    localparam int EVENT_W = $bits(scan_event_t);

    // Keyboard housekeeping bytes that never form part of a key event.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_ACK)  || (b == PS2_BAT)    || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; a write while full only lands if a read frees a slot that cycle.
module ps2_evt_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the empty flag guards every read of it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan controller: folds E0/F0 prefixes into key events and queues them for the consumer.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    scan_state_t   state;
    logic [TW-1:0] tmo_cnt;
    scan_event_t   push_ev;
    scan_event_t   head_ev;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Every non-prefix, non-housekeeping byte completes an event, whatever state we are in.
    // NOTE: all always_comb outputs get a default first so no latch is inferred.
    always_comb begin
        push    = 1'b0;
        push_ev = '{code: rx_data, ext: 1'b0, brk: 1'b0};
        if (rx_done_tick && rx_data != PS2_EXT && rx_data != PS2_BRK && !is_discard(rx_data)) begin
            push        = 1'b1;
            push_ev.ext = (state == EXT) || (state == EXT_BRK);
            push_ev.brk = (state == BRK) || (state == EXT_BRK);
        end
    end

    // A byte arriving on the expiry cycle is decoded first; the timeout only acts on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else if (rx_done_tick) begin
            tmo_cnt <= '0;
            if (push) begin
                state <= IDLE;
            end else if (state == IDLE && rx_data == PS2_EXT) begin
                state <= EXT;
            end else if (state == IDLE && rx_data == PS2_BRK) begin
                state <= BRK;
            end else if (state == EXT && rx_data == PS2_BRK) begin
                state <= EXT_BRK;
            end
        end else if (state != IDLE) begin
            if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_ev),
        .rd_en   (pop),
        .rd_data (head_ev),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign ev_code  = ev_valid ? head_ev.code : 8'h00;
    assign ev_ext   = ev_valid && head_ev.ext;
    assign ev_break = ev_valid && head_ev.brk;

    // rx_en keeps one slot spare for a byte the receiver may already be shifting in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_en <= (fifo_count < CW'(FIFO_DEPTH - 1));
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
